// File: rtl/cs_seq_pkg.sv
// ============================================================================
// Module   : cs_seq_pkg
// Brief    : Shared types and constants for the chip-select sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cs_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_HOLD   = 2'd3
    } state_e;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_SETUP  = 2'd1;
    localparam logic [1:0] ADDR_ACTIVE = 2'd2;
    localparam logic [1:0] ADDR_HOLD   = 2'd3;

    localparam int CTRL_START   = 0;
    localparam int CTRL_MAN_EN  = 1;
    localparam int CTRL_MAN_LVL = 2;
    localparam int CTRL_IRQ_CLR = 5;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_MAN_EN  = 1;
    localparam int STAT_CS      = 2;
    localparam int STAT_OWNER   = 3;
    localparam int STAT_SW_PEND = 4;
    localparam int STAT_IRQ     = 5;

    localparam logic OWNER_SW = 1'b0;
    localparam logic OWNER_HW = 1'b1;

endpackage

`default_nettype wire

// File: rtl/cs_seq_if.sv
// ============================================================================
// Module   : cs_seq_if
// Brief    : Avalon-MM slave bus plus hardware request/ack handshake.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface cs_seq_if #(
    parameter int DATA_W = 16
);
    logic [1:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              hw_req;
    logic              hw_ack;

    modport slave (
        input  address, chipselect, write_n, writedata, hw_req,
        output readdata, hw_ack
    );

    modport master (
        output address, chipselect, write_n, writedata, hw_req,
        input  readdata, hw_ack
    );
endinterface

`default_nettype wire

// File: rtl/cs_phase_timer.sv
// ============================================================================
// Module   : cs_phase_timer
// Brief    : Loadable down-counter; zero flags the last cycle of a phase.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cs_phase_timer #(
    parameter int CNT_W = 8
) (
    input  wire             clk,
    input  wire             reset_n,
    input  wire             load,
    input  wire [CNT_W-1:0] load_val,
    output logic            zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/cs_seq_ctrl.sv
// ============================================================================
// Module   : cs_seq_ctrl
// Brief    : Chip-select sequencer (SETUP/ACTIVE/HOLD) shared between software
//            and one hardware requester with round-robin arbitration.
//            Optional macro CS_IRQ_EN adds a completion interrupt output.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cs_seq_ctrl
    import cs_seq_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) (
    input  wire     clk,
    input  wire     reset_n,
    cs_seq_if.slave bus,
`ifdef CS_IRQ_EN
    output logic    irq,
`endif
    output logic    cs_n
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] setup_q, setup_d, active_q, active_d, hold_q, hold_d;
    logic [CNT_W-1:0] act_sh_q, act_sh_d, hold_sh_q, hold_sh_d;
    logic             man_en_q, man_en_d, man_lvl_q, man_lvl_d;
    logic             sw_pend_q, sw_pend_d, owner_q, owner_d;
    logic             last_owner_q, last_owner_d, cs_n_q, cs_n_d;

    logic             wr_en, ctrl_wr, start, sw_req, grant_sw, grant_hw, hold_done;
    logic             tmr_load, tmr_zero, irq_bit;
    logic [CNT_W-1:0] tmr_val;
    logic [DATA_W-1:0] rdata;
    logic             unused_wdata;

    assign wr_en     = bus.chipselect & ~bus.write_n;
    assign ctrl_wr   = wr_en && (bus.address == ADDR_CTRL);
    assign start     = ctrl_wr && bus.writedata[CTRL_START];
    assign sw_req    = sw_pend_q | start;
    assign hold_done = (state_q == ST_HOLD) && tmr_zero;
    assign unused_wdata = ^bus.writedata;

    always_comb begin
        setup_d   = setup_q;
        active_d  = active_q;
        hold_d    = hold_q;
        man_en_d  = man_en_q;
        man_lvl_d = man_lvl_q;
        if (wr_en) begin
            case (bus.address)
                ADDR_CTRL: begin
                    man_en_d  = bus.writedata[CTRL_MAN_EN];
                    man_lvl_d = bus.writedata[CTRL_MAN_LVL];
                end
                ADDR_SETUP:  setup_d  = bus.writedata[CNT_W-1:0];
                ADDR_ACTIVE: active_d = bus.writedata[CNT_W-1:0];
                ADDR_HOLD:   hold_d   = bus.writedata[CNT_W-1:0];
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        act_sh_d     = act_sh_q;
        hold_sh_d    = hold_sh_q;
        tmr_load     = 1'b0;
        tmr_val      = setup_q;
        grant_sw     = 1'b0;
        grant_hw     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!man_en_q) begin
                    // Contested: the side that did not own the last sequence wins
                    if (sw_req && bus.hw_req) begin
                        grant_sw = (last_owner_q == OWNER_HW);
                        grant_hw = ~grant_sw;
                    end else begin
                        grant_sw = sw_req;
                        grant_hw = bus.hw_req;
                    end
                end
                if (grant_sw || grant_hw) begin
                    state_d      = ST_SETUP;
                    owner_d      = grant_hw ? OWNER_HW : OWNER_SW;
                    last_owner_d = owner_d;
                    act_sh_d     = active_q;
                    hold_sh_d    = hold_q;
                    tmr_load     = 1'b1;
                    tmr_val      = setup_q;
                end
            end
            ST_SETUP: begin
                if (tmr_zero) begin
                    state_d  = ST_ACTIVE;
                    tmr_load = 1'b1;
                    tmr_val  = act_sh_q;
                end
            end
            ST_ACTIVE: begin
                if (tmr_zero) begin
                    state_d  = ST_HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = hold_sh_q;
                end
            end
            ST_HOLD: begin
                if (tmr_zero) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A granted start is consumed; a start arriving alongside a granted pend re-pends
        sw_pend_d = grant_sw ? (sw_pend_q & start) : (sw_pend_q | start);

        if ((state_d == ST_IDLE) && man_en_d) begin
            cs_n_d = ~man_lvl_d;
        end else begin
            cs_n_d = (state_d != ST_ACTIVE);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            setup_q      <= '0;
            active_q     <= '0;
            hold_q       <= '0;
            act_sh_q     <= '0;
            hold_sh_q    <= '0;
            man_en_q     <= 1'b0;
            man_lvl_q    <= 1'b0;
            sw_pend_q    <= 1'b0;
            owner_q      <= OWNER_SW;
            last_owner_q <= OWNER_HW;
            cs_n_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            setup_q      <= setup_d;
            active_q     <= active_d;
            hold_q       <= hold_d;
            act_sh_q     <= act_sh_d;
            hold_sh_q    <= hold_sh_d;
            man_en_q     <= man_en_d;
            man_lvl_q    <= man_lvl_d;
            sw_pend_q    <= sw_pend_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cs_n_q       <= cs_n_d;
        end
    end

    cs_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

`ifdef CS_IRQ_EN
    logic irq_flag_q, irq_flag_d;

    always_comb begin
        irq_flag_d = irq_flag_q;
        if (ctrl_wr && bus.writedata[CTRL_IRQ_CLR]) begin
            irq_flag_d = 1'b0;
        end
        if (hold_done && (owner_q == OWNER_SW)) begin
            irq_flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_flag_q <= 1'b0;
        end else begin
            irq_flag_q <= irq_flag_d;
        end
    end

    assign irq     = irq_flag_q;
    assign irq_bit = irq_flag_q;
`else
    assign irq_bit = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        case (bus.address)
            ADDR_CTRL: begin
                rdata[STAT_BUSY]    = (state_q != ST_IDLE);
                rdata[STAT_MAN_EN]  = man_en_q;
                rdata[STAT_CS]      = ~cs_n_q;
                rdata[STAT_OWNER]   = owner_q;
                rdata[STAT_SW_PEND] = sw_pend_q;
                rdata[STAT_IRQ]     = irq_bit;
            end
            ADDR_SETUP:  rdata[CNT_W-1:0] = setup_q;
            ADDR_ACTIVE: rdata[CNT_W-1:0] = active_q;
            ADDR_HOLD:   rdata[CNT_W-1:0] = hold_q;
        endcase
    end

    assign bus.readdata = rdata;
    assign bus.hw_ack   = hold_done && (owner_q == OWNER_HW);
    assign cs_n         = cs_n_q;

endmodule

`default_nettype wire

// File: tb/tb_cs_seq_ctrl.sv
// ============================================================================
// Module   : tb_cs_seq_ctrl
// Brief    : Directed bench for cs_seq_ctrl; optional CS_IRQ_EN coverage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cs_seq_ctrl;
    import cs_seq_pkg::*;

    logic clk;
    logic reset_n;
    logic cs_n;
`ifdef CS_IRQ_EN
    logic irq;
`endif
    int   checks = 0;
    int   errors = 0;

    cs_seq_if #(.DATA_W(16)) bus ();

    cs_seq_ctrl #(.DATA_W(16), .CNT_W(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
`ifdef CS_IRQ_EN
        .irq     (irq),
`endif
        .cs_n    (cs_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        step();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = ADDR_CTRL;
        bus.writedata  = '0;
    endtask

    task automatic check_rd(input string tag, input logic [1:0] a,
                            input logic [15:0] mask, input logic [15:0] exp);
        bus.address = a;
        #1;
        check(tag, {16'd0, bus.readdata & mask}, {16'd0, exp});
        bus.address = ADDR_CTRL;
    endtask

    // Bit i of each history word is the sample taken i cycles from now
    task automatic capture(input int n, output logic [31:0] cs_h,
                           output logic [31:0] busy_h, output logic [31:0] ack_h);
        cs_h = '0; busy_h = '0; ack_h = '0;
        for (int i = 0; i < n; i++) begin
            cs_h[i]   = cs_n;
            busy_h[i] = bus.readdata[STAT_BUSY];
            ack_h[i]  = bus.hw_ack;
            step();
        end
    endtask

    logic [31:0] cs_h, busy_h, ack_h;

    initial begin
        bus.address = ADDR_CTRL; bus.chipselect = 1'b0; bus.write_n = 1'b1;
        bus.writedata = '0; bus.hw_req = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n", {31'd0, cs_n}, 32'd1);
        check("rst_hw_ack", {31'd0, bus.hw_ack}, 32'd0);
        reset_n = 1'b1;
        step();
        check_rd("rst_stat", ADDR_CTRL, 16'hFFFF, 16'h0000);
        check_rd("rst_setup", ADDR_SETUP, 16'hFFFF, 16'h0000);

        // 1: basic software sequence 2/3/1
        wr(ADDR_SETUP, 16'd2);
        wr(ADDR_ACTIVE, 16'd3);
        wr(ADDR_HOLD, 16'd1);
        check_rd("t1_active_rd", ADDR_ACTIVE, 16'hFFFF, 16'h0003);
        wr(ADDR_CTRL, 16'h0001);
        capture(16, cs_h, busy_h, ack_h);
        check("t1_cs_hist", cs_h, 32'h0000FF87);
        check("t1_busy_hist", busy_h, 32'h000001FF);
        check("t1_no_ack", ack_h, 32'h0);
        check_rd("t1_stat", ADDR_CTRL, 16'h001F, 16'h0000);

        // 2: zero counts with hw_req held: back-to-back hw sequences
        wr(ADDR_SETUP, 16'd0);
        wr(ADDR_ACTIVE, 16'd0);
        wr(ADDR_HOLD, 16'd0);
        bus.hw_req = 1'b1;
        capture(16, cs_h, busy_h, ack_h);
        check("t2_cs_hist", cs_h, 32'h0000BBBB);
        check("t2_ack_hist", ack_h, 32'h00008888);
        check("t2_busy_hist", busy_h, 32'h0000EEEE);
        bus.hw_req = 1'b0;
        step();
        check_rd("t2_stat_owner_hw", ADDR_CTRL, 16'h001F, 16'h0008);

        // 3: contested arbitration after reset alternates owners
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        bus.hw_req = 1'b1;
        wr(ADDR_CTRL, 16'h0001);
        for (int r = 0; r < 5; r++) begin
            check_rd($sformatf("t3_owner_r%0d", r), ADDR_CTRL, 16'h0009,
                     (r % 2 == 0) ? 16'h0001 : 16'h0009);
            if (r % 2 == 0) begin
                wr(ADDR_CTRL, 16'h0001);
                check_rd($sformatf("t3_pend_r%0d", r), ADDR_CTRL, 16'h0010, 16'h0010);
                repeat (3) step();
            end else begin
                repeat (4) step();
            end
        end
        bus.hw_req = 1'b0;
        repeat (12) step();
        check_rd("t3_drained", ADDR_CTRL, 16'h0011, 16'h0000);

        // 4: ACTIVE rewritten mid-sequence affects only the next one
        wr(ADDR_ACTIVE, 16'd1);
        wr(ADDR_CTRL, 16'h0001);
        wr(ADDR_ACTIVE, 16'd5);
        capture(16, cs_h, busy_h, ack_h);
        check("t4_cs_cur", cs_h, 32'h0000FFFC);
        check_rd("t4_active_rd", ADDR_ACTIVE, 16'hFFFF, 16'h0005);
        wr(ADDR_CTRL, 16'h0001);
        capture(16, cs_h, busy_h, ack_h);
        check("t4_cs_next", cs_h, 32'h0000FF81);

        // 5: manual mode holds off requests
        wr(ADDR_CTRL, 16'h0006);
        check("t5_manual_low", {31'd0, cs_n}, 32'd0);
        bus.hw_req = 1'b1;
        wr(ADDR_CTRL, 16'h0007);
        check_rd("t5_stat_pend", ADDR_CTRL, 16'h001F, 16'h0016);
        capture(3, cs_h, busy_h, ack_h);
        check("t5_hold_cs", cs_h, 32'h0);
        check("t5_no_busy", busy_h, 32'h0);
        check("t5_no_ack", ack_h, 32'h0);
        wr(ADDR_CTRL, 16'h0000);
        check("t5_release_cs", {31'd0, cs_n}, 32'd1);
        check_rd("t5_still_idle", ADDR_CTRL, 16'h0001, 16'h0000);
        step();
        check_rd("t5_hw_started", ADDR_CTRL, 16'h0009, 16'h0009);
        bus.hw_req = 1'b0;
        repeat (20) step();
        check_rd("t5_drained", ADDR_CTRL, 16'h0011, 16'h0000);

`ifdef CS_IRQ_EN
        check("irq_set", {31'd0, irq}, 32'd1);
        check_rd("irq_stat", ADDR_CTRL, 16'h0020, 16'h0020);
        wr(ADDR_CTRL, 16'h0020);
        check("irq_clear", {31'd0, irq}, 32'd0);
`else
        check_rd("irq_stat_zero", ADDR_CTRL, 16'h0020, 16'h0000);
`endif

        // 6: async reset in ACTIVE
        wr(ADDR_CTRL, 16'h0001);
        wr(ADDR_CTRL, 16'h0001);
        check("t6_active_low", {31'd0, cs_n}, 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_async_cs", {31'd0, cs_n}, 32'd1);
        check_rd("t6_async_stat", ADDR_CTRL, 16'h001F, 16'h0000);
        #1;
        reset_n = 1'b1;
        repeat (2) step();
        check("t6_post_cs", {31'd0, cs_n}, 32'd1);
        check_rd("t6_post_stat", ADDR_CTRL, 16'h001F, 16'h0000);
        check_rd("t6_post_active", ADDR_ACTIVE, 16'hFFFF, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
